// File: rtl/spi_slave_ctrl_pkg.sv
// rtl/spi_slave_ctrl_pkg.sv - shared types and constants for the SPI responder
//
// Contents:
//   state_t              FSM state (IDLE, ACTIVE)
//   DEFAULT_WIDTH        default bits per SPI word
//   DEFAULT_SYNC_STAGES  default synchronizer depth
//   MISO_IDLE            level driven on miso while not selected
package spi_slave_ctrl_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int   DEFAULT_WIDTH       = 8;
    localparam int   DEFAULT_SYNC_STAGES = 2;
    localparam logic MISO_IDLE           = 1'b0;

endpackage

// File: rtl/spi_slave_ctrl_sync.sv
// rtl/spi_slave_ctrl_sync.sv - single-bit multi-flop synchronizer (module spi_sync)
//
// Parameters:
//   STAGES     number of flops in the chain (>=2)
//   RESET_VAL  level every flop takes during reset (the pin's idle level)
// Ports:
//   clk    in   system clock
//   rst_b  in   asynchronous active-low reset
//   d      in   asynchronous input pin
//   q      out  synchronized copy of d, STAGES clk cycles late
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_b,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_slave_ctrl.sv
// rtl/spi_slave_ctrl.sv - SPI mode-0 responder oversampled by the system clock
//
// Optional feature macro: SPI_SLAVE_CTRL_ERR_EN (adds tx_underrun and frame_err).
//
// Ports:
//   clk          in   system clock, at least 8x sclk
//   rst_b        in   asynchronous active-low reset
//   cs_b         in   SPI chip select, active low (asynchronous)
//   sclk         in   SPI clock (asynchronous)
//   mosi         in   SPI data from master
//   miso         out  SPI data to master, 0 while idle
//   rx_data      out  last complete received word
//   rx_valid     out  one-cycle pulse when rx_data updates
//   tx_data      in   next word to transmit
//   tx_valid     in   tx_data offered
//   tx_ready     out  holding register empty
//   busy         out  synchronized chip select is asserted
//   tx_underrun  out  (ERR_EN) word boundary reloaded zeros from an empty holding register
//   frame_err    out  (ERR_EN) chip select released mid-word
module spi_slave_ctrl
    import spi_slave_ctrl_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             cs_b,
    input  logic             sclk,
    input  logic             mosi,
    output logic             miso,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             busy
`ifdef SPI_SLAVE_CTRL_ERR_EN
    ,
    output logic             tx_underrun,
    output logic             frame_err
`endif
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic cs_s, sclk_s, mosi_s;
    logic cs_prev, sclk_prev;

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [WIDTH-2:0]   rx_shift;
    logic [WIDTH-1:0]   tx_shift;
    logic [WIDTH-1:0]   hold;
    logic               hold_full;

    logic             cs_fall, cs_rise, sclk_rise, sclk_fall;
    logic             start, stop, boundary, copy, tx_load;
    logic [WIDTH-1:0] hold_word, tx_next, rx_word;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_b(rst_b), .d(cs_b), .q(cs_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_b(rst_b), .d(sclk), .q(sclk_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_b(rst_b), .d(mosi), .q(mosi_s)
    );

    always_comb begin
        cs_fall   = cs_prev & ~cs_s;
        cs_rise   = ~cs_prev & cs_s;
        sclk_rise = ~sclk_prev & sclk_s;
        sclk_fall = sclk_prev & ~sclk_s;

        start    = (state == IDLE) & cs_fall;
        stop     = (state == ACTIVE) & cs_rise;
        // A falling sclk with the counter at 0 closes a word: the next word
        // is taken from the holding register instead of shifting.
        boundary = (state == ACTIVE) & ~cs_rise & sclk_fall & (bit_cnt == '0);
        copy     = start | boundary;

        hold_word = hold_full ? hold : '0;
        tx_next   = boundary ? hold_word : {tx_shift[WIDTH-2:0], 1'b0};
        rx_word   = {rx_shift, mosi_s};
        tx_load   = tx_valid & ~hold_full;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cs_prev   <= 1'b1;
            sclk_prev <= 1'b0;
            state     <= IDLE;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            miso      <= MISO_IDLE;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
        end else begin
            cs_prev   <= cs_s;
            sclk_prev <= sclk_s;
            rx_valid  <= 1'b0;

            // A simultaneous copy reads the old content (hold_word) while the
            // new word lands in the register and keeps it full.
            if (tx_load) begin
                hold      <= tx_data;
                hold_full <= 1'b1;
            end else if (copy) begin
                hold_full <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state    <= ACTIVE;
                        bit_cnt  <= '0;
                        tx_shift <= hold_word;
                        miso     <= hold_word[WIDTH-1];
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        // Any partial word is dropped silently.
                        state   <= IDLE;
                        bit_cnt <= '0;
                        miso    <= MISO_IDLE;
                    end else begin
                        if (sclk_rise) begin
                            rx_shift <= rx_word[WIDTH-2:0];
                            if (bit_cnt == LAST_BIT) begin
                                rx_data  <= rx_word;
                                rx_valid <= 1'b1;
                                bit_cnt  <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                        if (sclk_fall) begin
                            tx_shift <= tx_next;
                            miso     <= tx_next[WIDTH-1];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tx_ready = ~hold_full;
    assign busy     = (state == ACTIVE);

`ifdef SPI_SLAVE_CTRL_ERR_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            tx_underrun <= boundary & ~hold_full;
            frame_err   <= stop & (bit_cnt != '0);
        end
    end
`endif

endmodule
